// File: rtl/qspi_pmod_ctrl_if.sv
// qspi_pmod_ctrl_if: CPU-side request/response bundle for the QSPI PMOD controller
interface qspi_pmod_ctrl_if;
  logic [24:0] addr_in;
  logic [1:0]  len_in;
  logic        write_in;
  logic [31:0] wdata_in;
  logic        start;
  logic        start_ready;
  logic [31:0] rdata;
  logic        done;
  logic        error;
  modport master (output addr_in, len_in, write_in, wdata_in, start,
                  input  start_ready, rdata, done, error);
  modport slave  (input  addr_in, len_in, write_in, wdata_in, start,
                  output start_ready, rdata, done, error);
endinterface

// File: rtl/qspi_pmod_ctrl.sv
// qspi_pmod_ctrl: quad-mode EB read / 38 write master for the flash + 2 RAM PMOD
module qspi_pmod_ctrl #(
  parameter int DUMMY_CLKS = 6
) (
  input  logic             clk,
  input  logic             rst,
  qspi_pmod_ctrl_if.slave  bus,
  input  logic [3:0]       qspi_data_in,
  output logic [3:0]       qspi_data_out,
  output logic [3:0]       qspi_data_oe,
  output logic             qspi_clk_out,
  output logic             qspi_flash_select,
  output logic             qspi_ram_a_select,
  output logic             qspi_ram_b_select
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, END} state_t;
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        ph_q, ph_d;
  logic [31:0] sh_q, sh_d;
  logic [24:0] addr_q;
  logic [1:0]  len_q;
  logic        wr_q, err_q;
  logic [31:0] wdata_q, rdata_q;
  logic [5:0]  lim;
  logic        last, act;
  logic [4:0]  idx, aidx;
  logic [7:0]  cmd;
  // Per-state SPI clock budget and nibble positions derived from the clock index
  always_comb begin
    cmd  = wr_q ? 8'h38 : 8'hEB;
    lim  = state_q == CMD ? 6'd8 : state_q == ADDR ? 6'd6 : state_q == DUMMY ? 6'(DUMMY_CLKS)
         : ({4'd0, len_q} + 6'd1) << 1;
    last = {1'b0, cnt_q} == lim - 6'd1;
    idx  = {cnt_q[2:1], ~cnt_q[0], 2'b00};
    aidx = 5'd20 - {cnt_q[2:0], 2'b00};
    act  = state_q inside {CMD, ADDR, DUMMY, RDATA, WDATA};
  end
  // Next state: low phase -> high phase samples data, high phase -> low advances the clock index
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE: if (bus.start) begin
        if (bus.write_in && !bus.addr_in[24]) state_d = END;
        else state_d = CMD;
        cnt_d = '0;
        ph_d  = 1'b0;
        sh_d  = '0;
      end
      END: state_d = IDLE;
      default: if (!ph_q) begin
        ph_d = 1'b1;
        if (state_q == RDATA) sh_d[idx +: 4] = qspi_data_in;
      end else begin
        ph_d  = 1'b0;
        cnt_d = last ? '0 : cnt_q + 5'd1;
        if (last) begin
          case (state_q)
            CMD: state_d = ADDR;
            ADDR: if (wr_q) state_d = WDATA;
                  else if (DUMMY_CLKS == 0) state_d = RDATA;
                  else state_d = DUMMY;
            DUMMY: state_d = RDATA;
            default: state_d = END;
          endcase
        end
      end
    endcase
  end
  // State, request latch on acceptance, and read result capture on entry to END
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ph_q    <= 1'b0;
      sh_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      sh_q    <= sh_d;
      if (state_q == IDLE && bus.start) begin
        addr_q  <= bus.addr_in;
        len_q   <= bus.len_in;
        wr_q    <= bus.write_in;
        wdata_q <= bus.wdata_in;
        err_q   <= bus.write_in && !bus.addr_in[24];
      end
      if (state_q == RDATA && state_d == END) rdata_q <= sh_q;
    end
  end
  // Bus pins and CPU response decoded from registered state
  always_comb begin
    qspi_clk_out      = ph_q;
    qspi_flash_select = !(act && !addr_q[24]);
    qspi_ram_a_select = !(act && addr_q[24] && !addr_q[23]);
    qspi_ram_b_select = !(act && addr_q[24] && addr_q[23]);
    qspi_data_oe      = state_q == CMD ? 4'b0001 : (state_q == ADDR || state_q == WDATA) ? 4'b1111 : 4'b0000;
    qspi_data_out     = state_q == CMD ? {3'b000, cmd[3'd7 - cnt_q[2:0]]}
                      : state_q == ADDR ? addr_q[aidx +: 4]
                      : state_q == WDATA ? wdata_q[idx +: 4] : 4'h0;
    bus.start_ready   = state_q == IDLE;
    bus.done          = state_q == END;
    bus.error         = state_q == END && err_q;
    bus.rdata         = rdata_q;
  end
endmodule

// File: doc/qspi_pmod_ctrl.md
Name: qspi_pmod_ctrl

Overview:
Master-side QSPI controller that drives the team's QSPI PMOD: one flash and two RAMs, each with an active-low chip select, on a shared 4-bit bus. It converts single-word read/write requests from the CPU memory interface into quad-mode transactions: EB (quad read with 6 dummy clocks) or 38 (quad write). Each transaction is 1–4 bytes, little-endian. The block sits directly upstream of the PMOD flash/RAM and its simulation model, and directly downstream of the CPU bus.

Parameters:
DUMMY_CLKS, 6, SPI clocks between the last address nibble and the first read data nibble (EB only)

Ports:
clk  input  1  system clock; SPI clock runs at clk/2
rst  input  1  asynchronous reset, active-high
addr_in  input  25  byte address; bit24=0 selects flash, bit24=1 and bit23=0 selects RAM A, bit24=1 and bit23=1 selects RAM B; address field sent = addr_in[23:0]
len_in  input  2  transfer length minus 1 (0..3 gives 1..4 bytes)
write_in  input  1  1 = write (38), 0 = read (EB)
wdata_in  input  32  write data; byte k = wdata_in[8k+7:8k]
start  input  1  request strobe
start_ready  output  1  request accepted this cycle if start is also high
rdata  output  32  read data; valid when done=1
done  output  1  one-cycle completion pulse
error  output  1  valid with done; 1 = request rejected
qspi_data_in  input  4  bus input from the PMOD
qspi_data_out  output  4  bus output
qspi_data_oe  output  4  per-bit output enable
qspi_clk_out  output  1  SPI clock, idle low
qspi_flash_select  output  1  active-low
qspi_ram_a_select  output  1  active-low
qspi_ram_b_select  output  1  active-low

Behaviour:
- Reset (async, immediate, including mid-transaction):
  - All selects=1; qspi_clk_out=0; qspi_data_oe=0; qspi_data_out=0.
  - done=0; error=0; rdata=0; start_ready=1; state=IDLE.
- States: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, END.
- IDLE:
  - start_ready=1. Request accepted on the clk edge where start=1.
  - Address, length, direction and write data are latched on acceptance.
  - start_ready=0 in every other state; start is ignored there.
- Write to flash (write_in=1, addr_in[24]=0): no select asserted. Next cycle done=1, error=1. Return to IDLE.
- SPI clock (2 clk cycles per SPI clock):
  - Low phase: outputs change on the clk edge that drives qspi_clk_out 1->0, or on the first cycle after acceptance.
  - High phase: qspi_data_in is sampled on the clk edge that drives qspi_clk_out 0->1.
- Selects: the chosen select goes low on the cycle after acceptance and stays low through the last high phase.
- CMD: 8 SPI clocks. Command byte MSB first on data[0]; oe=0001; other data bits 0. Command is 0xEB for read, 0x38 for write.
- ADDR: 6 SPI clocks. addr[23:0] MSB nibble first; oe=1111.
- DUMMY (read only): DUMMY_CLKS SPI clocks; oe=0000.
- RDATA: 2*(len+1) SPI clocks; oe=0000.
  - Per byte, high nibble first; bytes fill rdata[7:0] first.
  - Bytes beyond len are returned as 0.
- WDATA: 2*(len+1) SPI clocks; oe=1111. Per byte, high nibble first, byte 0 first.
- END:
  - Select returns high and qspi_clk_out=0 (oe=0) on the cycle after the final high phase.
  - done=1 and error=0 in that same cycle; rdata is updated for reads.
  - IDLE follows the next cycle, so selects stay high for at least 2 clk cycles between transactions.
- Timing: with N SPI clocks, done is asserted N*2+1 cycles after acceptance.
  - Read: N = 8+6+DUMMY_CLKS+2*(len+1).
  - Write: N = 8+6+2*(len+1).
- rdata holds its value until the next read completes.

Test Plan:
- Flash contents 0x11,0x22,0x33,0x44 at 0x000100. Read, addr=0x0000100, len=3 -> data[0] bits during CMD = 1,1,1,0,1,0,1,1; address nibbles 0,0,0,1,0,0; 28 SPI clocks; done at cycle 57 after accept; rdata=0x44332211; error=0; only flash select low.
- Write RAM A, addr=0x1000010, len=1, wdata=0x0000BEEF -> cmd 0x38; 18 SPI clocks; nibbles E,F,B,E; model RAM A bytes 0x10=0xEF, 0x11=0xBE; done at cycle 37.
- Read RAM B, addr=0x1800010, len=0, after writing 0xA5 there -> rdata=0x000000A5; only RAM B select low; oe=0000 from the first DUMMY clock to the end.
- Write to flash, addr=0x0000000 -> no select asserted; done=1 and error=1 one cycle after accept; qspi_clk_out never toggles.
- Reset pulsed during ADDR of a read -> selects high and qspi_clk_out=0 immediately; no done pulse. A following read of 0x000100 returns the correct data.
- start held high continuously for two back-to-back reads -> the second request is accepted only in IDLE; selects stay high for 2 or more cycles between the two transactions.
